// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control path: opcodes, ALU
// operation codes, datapath mux encodings and the controller state type.
package cpu_pkg;

    localparam logic [4:0] OP_RTYPE = 5'h00;
    localparam logic [4:0] OP_ADDI  = 5'h08;
    localparam logic [4:0] OP_LW    = 5'h10;
    localparam logic [4:0] OP_SW    = 5'h11;
    localparam logic [4:0] OP_BEQ   = 5'h12;
    localparam logic [4:0] OP_J     = 5'h13;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;

    // ALU B operand select
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXE,
        S_RTWB, S_ADDIEXE, S_ADDIWB, S_BRANCH, S_JUMP, S_ILLEGAL, S_FAULT
    } state_e;

    // States that issue a memory request and wait on memReady.
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for memory handshakes.
//   clk_i, rstN_i : clock, async active-low reset
//   clr_i         : return count to zero (takes priority)
//   en_i          : count one waiting cycle
//   timeout_o     : this waiting cycle is the WAIT_LIMIT-th one
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic clk_i,
    input  logic rstN_i,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    // Fires while the last permitted waiting cycle is in progress, so the
    // controller leaves for FAULT on the edge that completes it.
    assign timeout_o = en_i && (cnt_q == CNT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU controller: sequences fetch/decode/execute/memory/writeback
// one state per cycle, with ready-handshaked memory states and a timeout.
//   clk, rstN           : clock, async active-low reset
//   opCode, funct, zero : instruction fields and ALU zero flag
//   memReady            : memory completes the current access this cycle
//   pcEn .. aluControl  : datapath enables, mux selects and ALU operation
//   illegalOp, memFault : sticky error flags, cleared only by reset
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [4:0] opCode,
    input  logic [3:0] funct,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcEn,
    output logic       irWrite,
    output logic       iOrD,
    output logic       memRead,
    output logic       memWrite,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSrc,
    output logic [3:0] aluControl,
    output logic       illegalOp,
    output logic       memFault
);

    state_e state_q, state_d;
    logic   illegal_q, fault_q;
    logic   wait_en, timeout;

    // Count only cycles spent stalled in a memory state; any advance or
    // non-memory state clears the count.
    assign wait_en = is_mem_state(state_q) && !memReady;

    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) u_wait (
        .clk_i    (clk),
        .rstN_i   (rstN),
        .clr_i    (!wait_en),
        .en_i     (wait_en),
        .timeout_o(timeout)
    );

    always_comb begin
        state_d    = state_q;
        pcEn       = 1'b0;
        irWrite    = 1'b0;
        iOrD       = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        regWrite   = 1'b0;
        regDst     = 1'b0;
        memToReg   = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = SRCB_REGB;
        pcSrc      = PCSRC_ALU;
        aluControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                irWrite = memReady;
                pcEn    = memReady;
                if (memReady)     state_d = S_DECODE;
                else if (timeout) state_d = S_FAULT;
            end
            S_DECODE: begin
                aluSrcB = SRCB_IMMSH;
                case (opCode)
                    OP_RTYPE:     state_d = S_RTEXE;
                    OP_ADDI:      state_d = S_ADDIEXE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
                state_d = (opCode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iOrD    = 1'b1;
                if (memReady)     state_d = S_MEMWB;
                else if (timeout) state_d = S_FAULT;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iOrD     = 1'b1;
                if (memReady)     state_d = S_FETCH;
                else if (timeout) state_d = S_FAULT;
            end
            S_RTEXE: begin
                aluSrcA    = 1'b1;
                aluControl = funct;
                state_d    = S_RTWB;
            end
            S_RTWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEXE: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA    = 1'b1;
                aluControl = ALU_SUB;
                pcSrc      = PCSRC_ALUOUT;
                pcEn       = zero;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcSrc   = PCSRC_JUMP;
                pcEn    = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = state_q;  // ILLEGAL, FAULT: park until reset
        endcase
        // The state register already sits in FETCH during reset; mask FETCH's
        // request and Mealy enables so nothing fires in the reset cycle.
        if (!rstN) begin
            pcEn     = 1'b0;
            irWrite  = 1'b0;
            memRead  = 1'b0;
            memWrite = 1'b0;
            regWrite = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == S_ILLEGAL);
            fault_q   <= fault_q | (state_d == S_FAULT);
        end
    end

    assign illegalOp = illegal_q;
    assign memFault  = fault_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy FSM that sequences the multicycle CPU datapath over 5-bit opcodes.
- Runs fetch, decode, execute, memory and writeback, one state per cycle.
- Each memory access waits on a ready handshake, bounded by a timeout counter.
- Replaces the single-cycle decoder when the shared instruction/data memory is used; drives PC enable, IR load, mux selects and ALU control.

Parameters:
- WAIT_LIMIT, 15: maximum cycles a memory state waits for memReady before faulting; must be ≥1.
- CNT_W, 4: wait counter width; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk, input, 1: single clock, rising edge.
- rstN, input, 1: asynchronous active-low reset.
- opCode, input, 5: IR[31:27], valid from DECODE onward.
- funct, input, 4: R-type ALU function field.
- zero, input, 1: ALU zero flag.
- memReady, input, 1: memory completes the current access this cycle.
- pcEn, output, 1: PC register load.
- irWrite, output, 1: IR load.
- iOrD, output, 1: memory address select; 0 = PC, 1 = ALUOut.
- memRead, output, 1: memory read request.
- memWrite, output, 1: memory write request.
- regWrite, output, 1: register file write.
- regDst, output, 1: destination select; 1 = rd, 0 = rt.
- memToReg, output, 1: writeback select; 1 = MDR.
- aluSrcA, output, 1: ALU A select; 0 = PC, 1 = regA.
- aluSrcB, output, 2: ALU B select; 00 = regB, 01 = const 4, 10 = signImm, 11 = signImm<<2.
- pcSrc, output, 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluControl, output, 4: ALU operation.
- illegalOp, output, 1: sticky undefined-opcode flag.
- memFault, output, 1: sticky memory timeout flag.

Behaviour:
- Reset (async, rstN = 0):
  - state = FETCH, wait counter = 0, illegalOp = 0, memFault = 0.
  - All other outputs are combinational from state and are 0 while in reset, except FETCH's static selects.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, ADDIEXE, ADDIWB, BRANCH, JUMP, ILLEGAL, FAULT.
- Memory states (FETCH, MEMRD, MEMWR):
  - Request (memRead or memWrite) is held every cycle until memReady.
  - State advances on the edge where memReady = 1.
  - The wait counter increments on each memReady = 0 cycle and clears on state exit.
  - If the counter reaches WAIT_LIMIT with memReady still 0, go to FAULT.
- FETCH:
  - Drives memRead = 1, iOrD = 0, aluSrcA = 0, aluSrcB = 01, ADD, pcSrc = 00.
  - irWrite = pcEn = memReady (Mealy), so PC+4 and IR load in the same cycle; then go to DECODE.
- DECODE:
  - Drives aluSrcA = 0, aluSrcB = 11, ADD (branch target into ALUOut).
  - Dispatch on opCode: RTYPE → RTEXE; ADDI → ADDIEXE; LW, SW → MEMADR; BEQ → BRANCH; J → JUMP; any other value → ILLEGAL.
- MEMADR: aluSrcA = 1, aluSrcB = 10, ADD; go to MEMRD for LW, MEMWR for SW.
- MEMRD: memRead = 1, iOrD = 1; on memReady go to MEMWB.
- MEMWB: regWrite = 1, memToReg = 1, regDst = 0; go to FETCH.
- MEMWR: memWrite = 1, iOrD = 1; on memReady go to FETCH.
- RTEXE: aluSrcA = 1, aluSrcB = 00, aluControl = funct; go to RTWB.
- RTWB: regWrite = 1, regDst = 1, memToReg = 0; go to FETCH.
- ADDIEXE: aluSrcA = 1, aluSrcB = 10, ADD; go to ADDIWB.
- ADDIWB: regWrite = 1, regDst = 0; go to FETCH.
- BRANCH: aluSrcA = 1, aluSrcB = 00, SUB, pcSrc = 01, pcEn = zero (Mealy); go to FETCH.
- JUMP: pcSrc = 10, pcEn = 1; go to FETCH.
- ILLEGAL: illegalOp set, all write enables 0, state holds until reset.
- FAULT: memFault set, all requests and write enables 0, state holds until reset.
- Latency with memReady = 1 at first request: R-type 4 cycles, ADDI 4, LW 5, SW 4, BEQ 3, J 3.
- Every output not listed for a state is 0; aluControl defaults to ADD.
- Reset asserted mid-instruction: returns to FETCH immediately; no write enable is asserted in the reset cycle.

Decomposition:
- Package cpu_pkg holds:
  - Opcodes: RTYPE = 5'h00, ADDI = 5'h08, LW = 5'h10, SW = 5'h11, BEQ = 5'h12, J = 5'h13.
  - ALU codes: ADD = 4'b0010, SUB = 4'b0110.
  - State enum typedef, and the aluSrcB and pcSrc encodings.
- One sub-module, mem_wait_timer: counter with clear/enable inputs and a timeout output, used for memory waits.

Test Plan:
- R-type flow: opCode = 00, funct = 0110, memReady = 1 → four states in sequence.
  - RTWB shows regWrite = 1, regDst = 1, aluControl = 0110 in RTEXE.
  - Back in FETCH at cycle 5.
- LW with memReady low 3 cycles in MEMRD → memRead and iOrD held high 4 cycles.
  - Then MEMWB with memToReg = 1; total instruction 8 cycles.
- BEQ: zero = 1 → pcEn = 1, pcSrc = 01 in BRANCH; zero = 0 → pcEn = 0; both return to FETCH after 3 cycles.
- Timeout: memReady held 0 in FETCH → memFault = 1 after exactly WAIT_LIMIT = 15 waiting cycles; state stays FAULT until rstN pulses low.
- Illegal: opCode = 5'h1F → ILLEGAL after DECODE, illegalOp = 1, no regWrite, memWrite or pcEn thereafter.
- Async reset: assert rstN = 0 mid-MEMWR, between clock edges → memWrite drops immediately, state = FETCH, flags cleared.
